// File: rtl/bank_sweeper.sv
// bank_sweeper: bus initiator that sweeps rows [START_ROW, END_ROW) of one
// grid bank chunk by chunk and clears '@' bits with fewer than 4 neighbours.
// Ports: clock, reset (sync, active-low), run (pass start pulse),
//   ack_in / partial_vec_in (bank completion + read data),
//   read_en_out / write_en_out / row_addr_out / col_addr_out /
//   partial_vec_out (request), changed_out / done_out (pass status),
//   updates_out (total removals since reset).
module bank_sweeper #(
    parameter int TX_DATA_WIDTH   = 8,
    parameter int COL_ADDR_WIDTH  = 4,
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int NUM_CHUNKS      = 2,
    parameter int MAX_ROWS        = 16,
    parameter int START_ROW       = 0,
    parameter int END_ROW         = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       ack_in,
    input  logic [TX_DATA_WIDTH-1:0]   partial_vec_in,
    output logic                       read_en_out,
    output logic                       write_en_out,
    output logic [BANK_ADDR_WIDTH-1:0] row_addr_out,
    output logic [COL_ADDR_WIDTH-1:0]  col_addr_out,
    output logic [TX_DATA_WIDTH-1:0]   partial_vec_out,
    output logic                       changed_out,
    output logic                       done_out,
    output logic [31:0]                updates_out
);

    localparam int W  = TX_DATA_WIDTH;
    localparam int KW = COL_ADDR_WIDTH + 1;
    localparam int RW = BANK_ADDR_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, LOAD, EVAL, WRITE, DONE} state_t;

    state_t                     state;
    logic [BANK_ADDR_WIDTH-1:0] row;
    logic [KW-1:0]              k;
    logic [1:0]                 li;
    logic                       prime;
    logic                       pass_flag;
    logic [W-1:0]               cur [3];
    logic [W-1:0]               nxt [3];
    logic [2:0]                 lbit;
    logic [31:0]                rm_count;

    logic [RW-1:0]  tgt_row;
    logic           skip;
    logic [W+1:0]   ext0, ext1, ext2;
    logic [3:0]     cnt;
    logic [W-1:0]   mask;
    logic [31:0]    pop;
    logic           adv;
    logic           last_chunk;
    logic           last_row;
    logic [W-1:0]   mid_post;

    // Row r-1+li; a wrap below zero lands far above MAX_ROWS.
    assign tgt_row = {2'b00, row} + RW'(li) - RW'(1);
    assign skip = (tgt_row >= RW'(MAX_ROWS)) ||
                  (k == KW'(NUM_CHUNKS));

    assign ext0 = {nxt[0][0], cur[0], lbit[0]};
    assign ext1 = {nxt[1][0], cur[1], lbit[1]};
    assign ext2 = {nxt[2][0], cur[2], lbit[2]};

    always_comb begin
        mask = '0;
        cnt  = '0;
        for (int i = 0; i < W; i++) begin
            cnt = 4'(ext0[i]) + 4'(ext0[i+1]) + 4'(ext0[i+2]) +
                  4'(ext1[i]) + 4'(ext1[i+2]) +
                  4'(ext2[i]) + 4'(ext2[i+1]) + 4'(ext2[i+2]);
            mask[i] = cur[1][i] && (cnt < 4'd4);
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + 32'(mask[i]);
        end
    end

    // Chunk finished: either nothing to clear, or its write was acked.
    assign adv = ((state == EVAL) && (mask == '0)) ||
                 ((state == WRITE) && write_en_out && ack_in);
    assign mid_post   = (state == WRITE) ? partial_vec_out : cur[1];
    assign last_chunk = (k == KW'(NUM_CHUNKS));
    assign last_row   = (({2'b00, row} + RW'(1)) == RW'(END_ROW));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            row             <= '0;
            k               <= '0;
            li              <= '0;
            prime           <= 1'b0;
            pass_flag       <= 1'b0;
            lbit            <= '0;
            rm_count        <= '0;
            read_en_out     <= 1'b0;
            write_en_out    <= 1'b0;
            row_addr_out    <= '0;
            col_addr_out    <= '0;
            partial_vec_out <= '0;
            changed_out     <= 1'b0;
            done_out        <= 1'b0;
            updates_out     <= '0;
            for (int j = 0; j < 3; j++) begin
                cur[j] <= '0;
                nxt[j] <= '0;
            end
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (run) begin
                        state       <= LOAD;
                        row         <= BANK_ADDR_WIDTH'(START_ROW);
                        k           <= '0;
                        li          <= '0;
                        prime       <= 1'b1;
                        pass_flag   <= 1'b0;
                        changed_out <= 1'b0;
                        done_out    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (li == 2'd3) begin
                        if (prime) begin
                            // First chunk of a row: no left neighbour.
                            for (int j = 0; j < 3; j++) begin
                                cur[j] <= nxt[j];
                            end
                            lbit  <= '0;
                            k     <= k + KW'(1);
                            li    <= '0;
                            prime <= 1'b0;
                        end else begin
                            state <= EVAL;
                        end
                    end else if (read_en_out) begin
                        if (ack_in) begin
                            nxt[li]     <= partial_vec_in;
                            read_en_out <= 1'b0;
                            li          <= li + 2'd1;
                        end
                    end else if (skip) begin
                        nxt[li] <= '0;
                        li      <= li + 2'd1;
                    end else begin
                        read_en_out  <= 1'b1;
                        row_addr_out <= BANK_ADDR_WIDTH'(tgt_row);
                        col_addr_out <= COL_ADDR_WIDTH'(k);
                    end
                end
                EVAL: begin
                    if (mask != '0) begin
                        state           <= WRITE;
                        write_en_out    <= 1'b1;
                        row_addr_out    <= row;
                        col_addr_out    <= COL_ADDR_WIDTH'(k - KW'(1));
                        partial_vec_out <= cur[1] & ~mask;
                        rm_count        <= pop;
                    end
                end
                WRITE: begin
                    if (ack_in) begin
                        write_en_out <= 1'b0;
                        updates_out  <= updates_out + rm_count;
                        pass_flag    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (adv) begin
                // Left edge for the next chunk uses the post-write mid row.
                lbit <= {cur[2][W-1], mid_post[W-1], cur[0][W-1]};
                for (int j = 0; j < 3; j++) begin
                    cur[j] <= nxt[j];
                end
                li <= '0;
                if (!last_chunk) begin
                    k     <= k + KW'(1);
                    state <= LOAD;
                end else if (last_row) begin
                    state       <= DONE;
                    done_out    <= 1'b1;
                    changed_out <= pass_flag | (state == WRITE);
                end else begin
                    row   <= row + BANK_ADDR_WIDTH'(1);
                    k     <= '0;
                    prime <= 1'b1;
                    state <= LOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_bank_sweeper.sv
// tb_bank_sweeper: bank model with configurable ack latency plus a
// scoreboard of expected write-backs built from a reference sweep.
module tb_bank_sweeper;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int BW = 8;
    localparam int NC = 2;
    localparam int MR = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          ack_in = 1'b0;
    logic [W-1:0]  partial_vec_in = '0;
    logic          read_en_out;
    logic          write_en_out;
    logic [BW-1:0] row_addr_out;
    logic [CW-1:0] col_addr_out;
    logic [W-1:0]  partial_vec_out;
    logic          changed_out;
    logic          done_out;
    logic [31:0]   updates_out;

    always #5 clock = ~clock;

    bank_sweeper #(
        .TX_DATA_WIDTH(W), .COL_ADDR_WIDTH(CW), .BANK_ADDR_WIDTH(BW),
        .NUM_CHUNKS(NC), .MAX_ROWS(MR), .START_ROW(0), .END_ROW(MR)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .ack_in(ack_in),
        .partial_vec_in(partial_vec_in),
        .read_en_out(read_en_out), .write_en_out(write_en_out),
        .row_addr_out(row_addr_out), .col_addr_out(col_addr_out),
        .partial_vec_out(partial_vec_out),
        .changed_out(changed_out), .done_out(done_out),
        .updates_out(updates_out)
    );

    typedef struct packed {
        logic [BW-1:0] row;
        logic [CW-1:0] col;
        logic [W-1:0]  data;
    } wr_t;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] mem  [MR][NC];
    logic [W-1:0] gold [MR][NC];
    wr_t exp_q[$];
    int exp_updates = 0;
    bit exp_changed = 0;
    int exp_reads = 0;
    int rd_count = 0;
    int wait_cycles = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gbit(input int r, input int col);
        logic [W-1:0] v;
        if (r < 0 || r >= MR || col < 0 || col >= NC * W) return 0;
        v = gold[r][col / W];
        return int'(v[col % W]);
    endfunction

    // Reference sweep: rows ascending, chunks ascending, each chunk judged
    // against the grid as updated so far, cleared bits applied per chunk.
    task automatic model_pass();
        exp_changed = 0;
        exp_reads = 0;
        for (int r = 0; r < MR; r++) begin
            for (int d = -1; d <= 1; d++) begin
                if (r + d >= 0 && r + d < MR) exp_reads += NC;
            end
            for (int c = 0; c < NC; c++) begin
                logic [W-1:0] m;
                logic [W-1:0] v;
                m = '0;
                v = gold[r][c];
                for (int i = 0; i < W; i++) begin
                    int col;
                    int n;
                    col = c * W + i;
                    n = 0;
                    if (v[i]) begin
                        for (int dr = -1; dr <= 1; dr++)
                            for (int dc = -1; dc <= 1; dc++)
                                if (dr != 0 || dc != 0)
                                    n += gbit(r + dr, col + dc);
                        if (n < 4) m[i] = 1'b1;
                    end
                end
                if (m != '0) begin
                    gold[r][c] = v & ~m;
                    exp_q.push_back({BW'(r), CW'(c), gold[r][c]});
                    exp_updates += $countones(m);
                    exp_changed = 1;
                end
            end
        end
    endtask

    task automatic clear_grid();
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < NC; c++) begin
                mem[r][c] = '0;
                gold[r][c] = '0;
            end
        exp_q.delete();
    endtask

    task automatic set_cell(input int r, input int c, input logic [W-1:0] v);
        mem[r][c] = v;
        gold[r][c] = v;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        exp_updates = 0;
    endtask

    // Bank model: samples requests on the falling edge, stalls wait_cycles,
    // then acks for one cycle and checks handshake rules throughout.
    initial begin
        bit pending;
        bit just_acked;
        bit snap_rd;
        int cnt;
        wr_t snap;
        wr_t e;
        pending = 0;
        just_acked = 0;
        snap_rd = 0;
        cnt = 0;
        forever begin
            @(negedge clock);
            ack_in = 1'b0;
            if (!reset) begin
                pending = 0;
                just_acked = 0;
            end else if (just_acked) begin
                just_acked = 0;
                check("en_drop", {read_en_out, write_en_out}, 0);
            end else if (read_en_out || write_en_out) begin
                check("en_excl", read_en_out & write_en_out, 0);
                if (!pending) begin
                    pending = 1;
                    cnt = 0;
                    snap = {row_addr_out, col_addr_out, partial_vec_out};
                    snap_rd = read_en_out;
                end else begin
                    check("stall_stable",
                          {read_en_out, write_en_out, row_addr_out,
                           col_addr_out, partial_vec_out},
                          {snap_rd, !snap_rd, snap});
                end
                if (cnt >= wait_cycles) begin
                    ack_in = 1'b1;
                    pending = 0;
                    just_acked = 1;
                    if (read_en_out) begin
                        check("rd_range",
                              (int'(row_addr_out) < MR) &&
                              (int'(col_addr_out) < NC), 1);
                        rd_count++;
                        if (int'(row_addr_out) < MR && int'(col_addr_out) < NC)
                            partial_vec_in = mem[row_addr_out][col_addr_out];
                        else
                            partial_vec_in = '0;
                    end else begin
                        check("wr_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("wr_data",
                                  {row_addr_out, col_addr_out, partial_vec_out},
                                  e);
                        end
                        if (int'(row_addr_out) < MR && int'(col_addr_out) < NC)
                            mem[row_addr_out][col_addr_out] = partial_vec_out;
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic run_pass(input string tag, input bit extra_run,
                            input int plan_upd, input bit plan_chg);
        int n;
        model_pass();
        rd_count = 0;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        if (extra_run) begin
            repeat (10) @(negedge clock);
            check({tag, "_busy"}, done_out, 0);
            run = 1'b1;
            @(negedge clock);
            run = 1'b0;
        end
        n = 0;
        while (!done_out && n < 20000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done"}, done_out, 1);
        check({tag, "_upd_model"}, updates_out, 32'(exp_updates));
        check({tag, "_upd_plan"}, updates_out, 32'(plan_upd));
        check({tag, "_chg_model"}, changed_out, exp_changed);
        check({tag, "_chg_plan"}, changed_out, plan_chg);
        check({tag, "_wr_left"}, exp_q.size(), 0);
        check({tag, "_reads"}, rd_count, exp_reads);
        for (int r = 0; r < MR; r++)
            check({tag, "_grid"}, {mem[r][1], mem[r][0]},
                  {gold[r][1], gold[r][0]});
    endtask

    initial begin
        int n;
        clear_grid();
        do_reset();
        check("reset_outs",
              {read_en_out, write_en_out, row_addr_out, col_addr_out,
               partial_vec_out, changed_out, done_out, updates_out}, 0);

        // single isolated bit
        set_cell(0, 0, 8'h08);
        exp_q.delete();
        run_pass("single", 0, 1, 1);
        check("single_row0", mem[0][0], 8'h00);

        // 3x3 block, three passes; third pass also gets a stray run
        do_reset();
        clear_grid();
        for (int r = 0; r < 3; r++) set_cell(r, 0, 8'h07);
        run_pass("blk1", 0, 4, 1);
        check("blk1_rows", {mem[0][0], mem[1][0], mem[2][0]}, 24'h020702);
        run_pass("blk2", 0, 9, 1);
        check("blk2_rows", {mem[0][0], mem[1][0], mem[2][0]}, 24'h000000);
        run_pass("blk3", 1, 9, 0);

        // block straddling the chunk boundary
        do_reset();
        clear_grid();
        for (int r = 0; r < 3; r++) begin
            set_cell(r, 0, 8'h80);
            set_cell(r, 1, 8'h01);
        end
        run_pass("edge", 0, 6, 1);

        // same 3x3 block with a slow bank
        do_reset();
        clear_grid();
        wait_cycles = 5;
        for (int r = 0; r < 3; r++) set_cell(r, 0, 8'h07);
        run_pass("stall", 0, 4, 1);
        check("stall_rows", {mem[0][0], mem[1][0], mem[2][0]}, 24'h020702);

        // reset while a write is waiting for ack
        wait_cycles = 20;
        clear_grid();
        set_cell(0, 0, 8'h08);
        model_pass();
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        n = 0;
        while (!write_en_out && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("rst_wr_seen", write_en_out, 1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_outs",
              {read_en_out, write_en_out, row_addr_out, col_addr_out,
               partial_vec_out, changed_out, done_out, updates_out}, 0);
        @(negedge clock);
        reset = 1'b1;
        exp_updates = 0;
        wait_cycles = 0;
        clear_grid();
        set_cell(0, 0, 8'h08);
        run_pass("after_rst", 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bank_sweeper.md
Name: bank_sweeper

Overview:
- Bus initiator that sits in front of one mem bank of the AOC4 grid store.
- Sweeps a contiguous row range [START_ROW, END_ROW) of the paper-roll grid in TX_DATA_WIDTH-bit column chunks and clears every '@' bit (1) with fewer than 4 set neighbours among its 8.
- Writes cleared chunks back to the bank and accumulates a removal count.
- Top instantiates one per bank and re-pulses run until no sweeper reports changed.

Parameters:
- TX_DATA_WIDTH, 8, chunk width in bits. Bit i of chunk c is column c*TX_DATA_WIDTH+i.
- COL_ADDR_WIDTH, 4, width of the chunk index.
- BANK_ADDR_WIDTH, 8, width of the global row address.
- NUM_CHUNKS, 2, chunks per row. Columns outside [0, NUM_CHUNKS*TX_DATA_WIDTH) read as 0.
- MAX_ROWS, 16, total grid rows. Rows outside [0, MAX_ROWS) read as 0.
- START_ROW, 0, first row owned.
- END_ROW, 16, one past last row owned.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- run  in  1  one-cycle start pulse for one sweep pass.
- ack_in  in  1  bank completion for the current request; read data valid in the same cycle.
- partial_vec_in  in  TX_DATA_WIDTH  bank read data.
- read_en_out  out  1  read request.
- write_en_out  out  1  write request.
- row_addr_out  out  BANK_ADDR_WIDTH  request row.
- col_addr_out  out  COL_ADDR_WIDTH  request chunk index.
- partial_vec_out  out  TX_DATA_WIDTH  write data.
- changed_out  out  1  last completed pass removed at least one bit.
- done_out  out  1  pass complete / idle-after-pass.
- updates_out  out  32  total removals since reset.

Behaviour:
- Reset (reset==0): state IDLE; all outputs 0; updates_out 0; buffers cleared. Applies at any point, including mid-request; an outstanding request is abandoned.
- Request handshake:
  - At most one request outstanding; read_en_out and write_en_out are never both 1.
  - Once asserted, en, row_addr_out, col_addr_out and partial_vec_out stay stable until the cycle ack_in==1.
  - En drops the cycle after ack.
  - ack_in while no request is outstanding is ignored.
- States: IDLE, LOAD, EVAL, WRITE, DONE.
- IDLE/DONE:
  - On run, go to LOAD for row START_ROW, chunk 0.
  - Clear changed_out and done_out; clear the pass-local removal flag.
  - run in any other state is ignored.
- LOAD:
  - Fetches the lookahead chunk k for rows r-1, r, r+1, in that order, into the next-buffer.
  - Rows outside [0, MAX_ROWS) are loaded as 0 with no request issued (0 bus cycles).
  - When k==NUM_CHUNKS, the next-buffer is all 0 with no request.
  - Row-start priming: for the first chunk of a row, LOAD runs for k=0, then shifts next-buffer into cur-buffer, left-edge bits become 0, then LOADs k=1.
- EVAL (1 cycle) for chunk c=k-1 of row r:
  - Count uses the saved left-edge bit (bit W-1 of the previous cur chunk of each of the 3 rows), the cur chunk, and bit 0 of the next-buffer.
  - removable mask = cur_mid & (neighbour count < 4).
  - If mask!=0, go to WRITE with data cur_mid & ~mask.
  - Otherwise: save the edge bits, shift next into cur, and go to LOAD for k+1. After c==NUM_CHUNKS-1, advance to the next row instead.
- WRITE:
  - Issue the write to (r, c).
  - On ack: updates_out += popcount(mask), set the pass-changed flag.
  - Update cur_mid with the written value. Saved edge bits use the post-write value.
  - Continue as EVAL's no-mask path.
- Ordering:
  - Rows are processed ascending. Row r+1's reads occur after row r's write-backs, so they see the cleared data.
  - Evaluation within one chunk uses a single snapshot.
- After the last chunk of END_ROW-1: go to DONE; done_out=1, changed_out=pass flag. Both hold until the next run or reset.
- updates_out wraps modulo 2^32; it is not cleared by run.

Test Plan:
- Single '@' at row 0 col 3 (bank row0 chunk0=0x08), run -> one write (row 0, col 0, data 0x00), updates_out=1, changed_out=1, done_out=1.
- 3x3 block rows 0-2 cols 0-2 (chunk0=0x07 each), run three times:
  - pass 1 -> updates 4, rows 0/1/2 become 0x02/0x07/0x02, changed 1;
  - pass 2 -> updates_out 9, all zero, changed 1;
  - pass 3 -> no write requests, changed 0, updates_out 9.
- Chunk-boundary: rows 0-2 cols 7,8 set (chunk0=0x80, chunk1=0x01), one pass -> updates_out=6. Writes hit both col 0 and col 1 of rows 0-2; no write issued for an all-zero mask chunk.
- Bank holding ack_in low 5 cycles per request -> read_en/write_en, row/col addr and data stable every stalled cycle; never both enables high; results identical to the zero-wait run.
- START_ROW=0, row -1 handling: no read request is ever issued with an out-of-range row; run asserted mid-pass is ignored (pass count unchanged).
- reset driven 0 during WRITE wait -> next cycle all outputs 0, updates_out 0; subsequent run completes a normal pass.
